// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer
// USB full-speed transmit engine. When a tx_packet command is given it serialises
// SYNC, PID, the optional payload (popped from data_buffer) and CRC16, then EOP.
// The bit stream is bit-stuffed and NRZI encoded onto dp_out/dm_out.
//
// Parameters
//   CLKS_PER_BIT        clk cycles per USB bit time (>= 2)
// Ports
//   clk                 in   system clock, rising edge
//   rst                 in   asynchronous active-high reset
//   tx_packet[1:0]      in   00 none, 01 DATA0, 10 ACK, 11 NAK (sampled in IDLE only)
//   buffer_occupancy    in   payload byte count, latched with tx_packet
//   tx_packet_data      in   show-ahead head byte of data_buffer
//   tx_abort            in   (USB_TX_ABORT_EN only) abandon packet with a stuff error
//   get_tx_packet_data  out  one-cycle pop strobe
//   tx_status           out  1 while a packet is on the line
//   dp_out / dm_out     out  D+/D- line drive
//
// Build option: define USB_TX_ABORT_EN to add the tx_abort input and abort sequence.
module usb_tx_packetizer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
`ifdef USB_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       get_tx_packet_data,
  output logic       tx_status,
  output logic       dp_out,
  output logic       dm_out
);
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    CMD_DATA0 = 2'b01;
  localparam logic [1:0]    CMD_ACK   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP_SE0, S_EOP_J, S_ABORT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;     // bit index within the current field
  logic [2:0]    ones_q;    // consecutive 1s in the stuffable stream
  logic [7:0]    byte_q;    // field currently being sent
  logic [1:0]    cmd_q;
  logic [6:0]    rem_q;     // payload bytes not yet popped
  logic [15:0]   crc_q;     // reflected CRC16 register
  logic          status_q, get_q, dp_q, dm_q;
`ifdef USB_TX_ABORT_EN
  logic          abort_q;
`endif

  // Reflected form of poly 0x8005: LSB-first data shifts right against 0xA001.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] pid_of(input logic [1:0] c);
    case (c)
      CMD_DATA0: return 8'hC3;
      CMD_ACK:   return 8'hD2;
      default:   return 8'h5A;
    endcase
  endfunction

  logic   wrap, stuffable, stuff_due, abort_go, next_bit, nf_pop;
  state_t nf_state;
  logic [7:0] nf_byte;

  assign wrap      = (cnt_q == CNT_MAX);
  assign stuffable = (state_q == S_PID) || (state_q == S_DATA) ||
                     (state_q == S_CRC_LO) || (state_q == S_CRC_HI);
  assign stuff_due = stuffable && (ones_q == 3'd6);
  assign next_bit  = byte_q[idx_q + 3'd1];
`ifdef USB_TX_ABORT_EN
  assign abort_go  = stuffable && (abort_q || tx_abort);
`else
  assign abort_go  = 1'b0;
`endif

  // Field that follows the current one once its last bit has been sent.
  always_comb begin
    nf_state = S_EOP_SE0;
    nf_byte  = 8'h00;
    nf_pop   = 1'b0;
    case (state_q)
      S_SYNC: begin
        nf_state = S_PID;
        nf_byte  = pid_of(cmd_q);
      end
      S_PID, S_DATA: begin
        if (cmd_q == CMD_DATA0) begin
          if (rem_q != 7'd0) begin
            nf_state = S_DATA;
            nf_byte  = tx_packet_data;
            nf_pop   = 1'b1;
          end else begin
            nf_state = S_CRC_LO;
            nf_byte  = ~crc_q[7:0];
          end
        end
      end
      S_CRC_LO: begin
        nf_state = S_CRC_HI;
        nf_byte  = ~crc_q[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ones_q   <= '0;
      byte_q   <= '0;
      cmd_q    <= '0;
      rem_q    <= '0;
      crc_q    <= 16'hFFFF;
      status_q <= 1'b0;
      get_q    <= 1'b0;
      dp_q     <= 1'b1;
      dm_q     <= 1'b0;
`ifdef USB_TX_ABORT_EN
      abort_q  <= 1'b0;
`endif
    end else begin
      get_q <= 1'b0;
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (tx_packet != 2'b00) begin
          state_q  <= S_SYNC;
          cmd_q    <= tx_packet;
          rem_q    <= buffer_occupancy;
          idx_q    <= '0;
          byte_q   <= 8'h80;
          ones_q   <= '0;
          crc_q    <= 16'hFFFF;
          status_q <= 1'b1;
          // First SYNC bit is 0: J -> K straight away.
          dp_q     <= 1'b0;
          dm_q     <= 1'b1;
`ifdef USB_TX_ABORT_EN
          abort_q  <= 1'b0;
`endif
        end
      end else begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
`ifdef USB_TX_ABORT_EN
        if (stuffable && tx_abort) abort_q <= 1'b1;
`endif
        if (wrap) begin
          if (abort_go) begin
            // Eight 1s, never stuffed: the line simply holds.
            state_q <= S_ABORT;
            idx_q   <= '0;
            byte_q  <= 8'hFF;
`ifdef USB_TX_ABORT_EN
            abort_q <= 1'b0;
`endif
          end else if (stuff_due) begin
            // Stuffed 0 takes its own bit time; field position does not advance.
            dp_q   <= ~dp_q;
            dm_q   <= dp_q;
            ones_q <= '0;
          end else if (state_q == S_EOP_SE0) begin
            if (idx_q == 3'd1) begin
              state_q <= S_EOP_J;
              dp_q    <= 1'b1;
              dm_q    <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (state_q == S_EOP_J) begin
            state_q  <= S_IDLE;
            status_q <= 1'b0;
          end else if (idx_q != 3'd7) begin
            idx_q <= idx_q + 3'd1;
            if (!next_bit) begin
              dp_q <= ~dp_q;
              dm_q <= dp_q;
            end
            if (stuffable) ones_q <= next_bit ? ones_q + 3'd1 : 3'd0;
          end else begin
            state_q <= nf_state;
            idx_q   <= '0;
            byte_q  <= nf_byte;
            if (nf_state == S_EOP_SE0) begin
              dp_q <= 1'b0;
              dm_q <= 1'b0;
            end else begin
              if (!nf_byte[0]) begin
                dp_q <= ~dp_q;
                dm_q <= dp_q;
              end
              ones_q <= nf_byte[0] ? ones_q + 3'd1 : 3'd0;
            end
            if (nf_pop) begin
              get_q <= 1'b1;
              rem_q <= rem_q - 7'd1;
              crc_q <= crc16_byte(crc_q, tx_packet_data);
            end
          end
        end
      end
    end
  end

  assign get_tx_packet_data = get_q;
  assign tx_status          = status_q;
  assign dp_out             = dp_q;
  assign dm_out             = dm_q;
endmodule
